// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the WB stage
// and the MDU. MDU results are queued and drained in idle pipe slots. A head
// blocked for MAX_WAIT cycles forces a one-cycle registered pipe stall.
// Optional feature: define WB_ARB_BYPASS_EN to write an MDU result straight
// through when the queue is empty and the pipe slot is idle.
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_wdata,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_rd,
  input  logic [31:0]              mdu_wdata,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     stall_pipe,
  output logic [$clog2(DEPTH):0]   q_count,
  input  logic [4:0]               rs1_addr,
  input  logic [4:0]               rs2_addr,
  output logic                     rs1_pending,
  output logic                     rs2_pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, STEAL} state_t;

  logic [4:0]       q_rd   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    wptr, rptr;
  state_t           state;
  logic [AW-1:0]    age;
  logic [AW-1:0]    age_inc;

  logic pipe_busy, head_valid, pop, push, accept, bypass, blocked;

  assign pipe_busy  = pipe_we && (pipe_rd != 5'd0) && !stall_pipe;
  assign head_valid = (q_count != '0);
  assign mdu_ready  = !rst && (q_count < CW'(DEPTH));
  assign accept     = mdu_valid && mdu_ready;
  // During a steal pipe_busy is forced low, so the head always wins the port.
  assign pop        = head_valid && !pipe_busy;
  assign blocked    = head_valid && pipe_busy;
  assign age_inc    = age + AW'(1);

`ifdef WB_ARB_BYPASS_EN
  assign bypass = !head_valid && !pipe_busy && !stall_pipe && accept &&
                  (mdu_rd != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Results for x0 are swallowed; bypassed results never enter the queue.
  assign push = accept && (mdu_rd != 5'd0) && !bypass;

  // Write-port grant: pipe slot, then queue head, then bypassed MDU result.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (!rst) begin
      if (pipe_busy) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_rd;
        rf_wdata = pipe_wdata;
      end else if (head_valid) begin
        rf_we    = 1'b1;
        rf_waddr = q_rd[rptr];
        rf_wdata = q_data[rptr];
      end else if (bypass) begin
        rf_we    = 1'b1;
        rf_waddr = mdu_rd;
        rf_wdata = mdu_wdata;
      end
    end
  end

  // Queue payload storage; validity is tracked separately so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wptr]   <= mdu_rd;
      q_data[wptr] <= mdu_wdata;
    end
  end

  // Queue pointers, per-entry valid bits and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      q_vld   <= '0;
      q_count <= '0;
    end else begin
      if (push) begin
        wptr        <= wptr + PW'(1);
        q_vld[wptr] <= 1'b1;
      end
      if (pop) begin
        rptr        <= rptr + PW'(1);
        q_vld[rptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Steal FSM: age counts blocked cycles; reaching MAX_WAIT raises a
  // one-cycle registered stall that hands the port to the queue head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      age        <= '0;
      stall_pipe <= 1'b0;
    end else begin
      case (state)
        IDLE, WAIT: begin
          if (blocked) begin
            if (age_inc == AW'(MAX_WAIT)) begin
              state      <= STEAL;
              age        <= '0;
              stall_pipe <= 1'b1;
            end else begin
              state <= WAIT;
              age   <= age_inc;
            end
          end else begin
            state <= IDLE;
            age   <= '0;
          end
        end
        STEAL: begin
          state      <= IDLE;
          age        <= '0;
          stall_pipe <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          age        <= '0;
          stall_pipe <= 1'b0;
        end
      endcase
    end
  end

  // Source-operand lookup against queued entries and the incoming result.
  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && (q_rd[i] == rs1_addr)) rs1_pending = 1'b1;
      if (q_vld[i] && (q_rd[i] == rs2_addr)) rs2_pending = 1'b1;
    end
    if (mdu_valid && (mdu_rd == rs1_addr)) rs1_pending = 1'b1;
    if (mdu_valid && (mdu_rd == rs2_addr)) rs2_pending = 1'b1;
    if (rs1_addr == 5'd0) rs1_pending = 1'b0;
    if (rs2_addr == 5'd0) rs2_pending = 1'b0;
  end

endmodule
